// File: rtl/atom_npu_pkg.sv
// Shared types and elaboration helpers for the atomNPU dot-product engine.
package atom_npu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } npu_state_t;

  // Narrowest accumulator that cannot overflow over vec_len full-width products.
  function automatic int min_acc_w(input int data_w, input int vec_len);
    return 2 * data_w + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/atom_npu_sat.sv
// Result stage: arithmetic shift, optional ReLU, then signed saturation to OUT_W.
// Define ATOM_NPU_RELU_EN to clamp negative results to zero.
module atom_npu_sat #(
  parameter int ACC_W     = 11,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] result
);

  // One guard bit beyond the wider of the two widths keeps the clamp compare exact.
  localparam int EW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] rect;
  logic signed [EW-1:0]    wide;
  logic signed [EW-1:0]    clamped;

  always_comb begin
    shifted = acc >>> OUT_SHIFT;
`ifdef ATOM_NPU_RELU_EN
    rect = shifted[ACC_W-1] ? '0 : shifted;
`else
    rect = shifted;
`endif
    wide = $signed({{(EW-ACC_W){rect[ACC_W-1]}}, rect});
    if (wide > SAT_MAX) begin
      clamped = SAT_MAX;
    end else if (wide < SAT_MIN) begin
      clamped = SAT_MIN;
    end else begin
      clamped = wide;
    end
    result = clamped[OUT_W-1:0];
  end

endmodule

// File: rtl/atom_npu_dot.sv
// Streaming signed dot-product engine: start, VEC_LEN MAC beats, scaled result held
// on a valid/ready port. ReLU output mode is selected by ATOM_NPU_RELU_EN.
module atom_npu_dot
  import atom_npu_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int VEC_LEN   = 8,
  parameter int ACC_W     = 2 * DATA_W + $clog2(VEC_LEN),
  parameter int OUT_SHIFT = 0,
  parameter int OUT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] input_data,
  input  logic [DATA_W-1:0] weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  output_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam int PROD_W = 2 * DATA_W;

  if (VEC_LEN < 2) begin : g_vec_len_chk
    $error("atom_npu_dot: VEC_LEN must be at least 2");
  end
  if (ACC_W < min_acc_w(DATA_W, VEC_LEN)) begin : g_acc_w_chk
    $error("atom_npu_dot: ACC_W too small for DATA_W/VEC_LEN");
  end
  if (OUT_SHIFT < 0 || OUT_SHIFT > ACC_W - 1) begin : g_shift_chk
    $error("atom_npu_dot: OUT_SHIFT out of range");
  end

  npu_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [OUT_W-1:0]  sat_res;

  assign prod    = $signed(input_data) * $signed(weight);
  assign acc_sum = acc_q + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

  // Scaling sees the sum including the current beat so the last beat can register the result.
  atom_npu_sat #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_sat (
    .acc   (acc_sum),
    .result(sat_res)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_data_d  = out_data_q;
    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = ACCUM;
            acc_d      = '0;
            cnt_d      = '0;
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(VEC_LEN - 1)) begin
              state_d     = OUTPUT;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
              out_data_d  = sat_res;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign output_data = out_data_q;

endmodule

// File: tb/tb_atom_npu_dot.sv
// Randomised self-checking bench for atom_npu_dot; a second instance runs with OUT_SHIFT=2.
module tb_atom_npu_dot;

  localparam int DW = 4;
  localparam int VL = 4;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] input_data = '0;
  logic [DW-1:0] weight = '0;

  logic          in_ready, out_valid, busy, done;
  logic [OW-1:0] output_data;
  logic          in_ready2, out_valid2, busy2, done2;
  logic [OW-1:0] output_data2;

  int errors = 0;
  int checks = 0;
  int vx[VL];
  int vw[VL];

  always #5 clk = ~clk;

  atom_npu_dot #(.DATA_W(DW), .VEC_LEN(VL), .OUT_SHIFT(0), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_data(input_data), .weight(weight),
    .out_valid(out_valid), .out_ready(out_ready), .output_data(output_data),
    .busy(busy), .done(done)
  );

  atom_npu_dot #(.DATA_W(DW), .VEC_LEN(VL), .OUT_SHIFT(2), .OUT_W(OW)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .in_valid(in_valid), .in_ready(in_ready2),
    .input_data(input_data), .weight(weight),
    .out_valid(out_valid2), .out_ready(out_ready), .output_data(output_data2),
    .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact integer dot product, floor shift, optional ReLU, clamp to OUT_W.
  function automatic int model(input int shift);
    int acc;
    int r;
    acc = 0;
    for (int i = 0; i < VL; i++) acc += vx[i] * vw[i];
    r = acc >>> shift;
`ifdef ATOM_NPU_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic int s8(input logic [OW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic beat(input int x, input int w, input int gap_max);
    int gaps;
    gaps = int'($urandom_range(0, gap_max));
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("gap_in_ready", int'(in_ready), 1);
    end
    in_valid   = 1'b1;
    input_data = DW'(x);
    weight     = DW'(w);
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_ready", int'(in_ready), 1);
    chk("start_busy", int'(busy), 1);
  endtask

  task automatic run_vec(input string name, input int gap_max, input int hold);
    int e0;
    int e2;
    int held;
    e0 = model(0);
    e2 = model(2);
    do_start();
    for (int i = 0; i < VL; i++) beat(vx[i], vw[i], gap_max);
    in_valid = 1'b0;
    chk({name, "_out_valid"}, int'(out_valid), 1);
    chk({name, "_result"}, s8(output_data), e0);
    chk({name, "_in_ready_low"}, int'(in_ready), 0);
    chk({name, "_out_valid_s2"}, int'(out_valid2), 1);
    chk({name, "_result_s2"}, s8(output_data2), e2);
    held = s8(output_data);
    for (int k = 0; k < hold; k++) begin
      start = (k == 1);
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, "_hold_valid"}, int'(out_valid), 1);
      chk({name, "_hold_stable"}, s8(output_data), held);
      chk({name, "_hold_in_ready"}, int'(in_ready), 0);
      chk({name, "_hold_done"}, int'(done), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_rel_valid"}, int'(out_valid), 0);
    chk({name, "_rel_done"}, int'(done), 1);
    chk({name, "_rel_busy"}, int'(busy), 0);
    @(posedge clk); #1;
    chk({name, "_done_single"}, int'(done), 0);
    chk({name, "_idle_busy"}, int'(busy), 0);
    $display("vec %s: result=%0d exp=%0d shift2=%0d exp=%0d hold=%0d",
             name, s8(output_data), e0, s8(output_data2), e2, hold);
  endtask

  task automatic set_vec(input int x0, input int x1, input int x2, input int x3,
                         input int w0, input int w1, input int w2, input int w3);
    vx[0] = x0; vx[1] = x1; vx[2] = x2; vx[3] = x3;
    vw[0] = w0; vw[1] = w1; vw[2] = w2; vw[3] = w3;
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_in_ready"}, int'(in_ready), 0);
    chk({name, "_out_valid"}, int'(out_valid), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2;
    check_idle_outputs("reset");
    chk("reset_output_data", s8(output_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    set_vec(1, 2, 3, 4, 1, 1, 1, 1);
    run_vec("ramp", 0, 0);
    set_vec(-8, -8, -8, -8, -8, -8, -8, -8);
    run_vec("sat_hi", 0, 0);
    set_vec(7, 7, 7, 7, -8, -8, -8, -8);
    run_vec("sat_lo", 0, 1);
    set_vec(5, 5, 5, 5, 3, 3, 3, 3);
    run_vec("shift", 1, 0);
    set_vec(3, -2, 6, -5, 4, 7, -3, 2);
    run_vec("backpressure", 0, 5);

    // in_valid in IDLE is ignored; clear wins over start.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("idle_ignore_valid", int'(busy), 0);
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    start = 1'b0;
    chk("clear_beats_start", int'(busy), 0);

    do_start();
    beat(2, 3, 2);
    beat(-4, 5, 2);
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_idle_outputs("clear");
    @(posedge clk); #1;
    chk("clear_no_done", int'(done), 0);
    chk("clear_no_valid", int'(out_valid), 0);
    set_vec(1, 1, 1, 1, 2, 2, 2, 2);
    run_vec("after_clear", 2, 0);

    // Asynchronous reset in the middle of a vector.
    do_start();
    beat(7, 7, 0);
    beat(7, 7, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    chk("midreset_output_data", s8(output_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < VL; i++) begin
        vx[i] = int'($urandom_range(0, 15)) - 8;
        vw[i] = int'($urandom_range(0, 15)) - 8;
      end
      run_vec($sformatf("rand%0d", t), 2, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
